// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared enable-polarity constants for the FIFO controller and its SRAM port
package fifo_ctrl_pkg;
  localparam logic ChipEnable  = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: W-bit wrap-around pointer that advances by one on inc
module fifo_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  logic [W-1:0] ptr_d, ptr_q;
  // next pointer value, wrapping naturally at 2**W
  always_comb begin
    ptr_d = inc ? ptr_q + W'(1) : ptr_q;
  end
  // pointer register, cleared by the active-low async reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
  assign ptr = ptr_q;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO controller driving an external registered-read SRAM
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err,
  output logic                  sram_ce,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic                  sram_we,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  output logic                  sram_re,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);
  localparam logic [ADDR_WIDTH:0] Depth = DATA_DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AfLvl = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AeLvl = AE_LEVEL[ADDR_WIDTH:0];
  logic [ADDR_WIDTH:0] wptr, rptr;
  logic en, push_ok, pop_ok, push_err, pop_err;
  logic pop_valid_d, pop_valid_q, overflow_d, overflow_q, underflow_d, underflow_q;
  fifo_ptr #(.W(ADDR_WIDTH + 1)) u_wptr (.clk(clk), .rst(rst), .inc(push_ok), .ptr(wptr));
  fifo_ptr #(.W(ADDR_WIDTH + 1)) u_rptr (.clk(clk), .rst(rst), .inc(pop_ok), .ptr(rptr));
  // occupancy flags, accept decisions, SRAM strobes and next sticky/valid state
  always_comb begin
    count        = wptr - rptr;
    full         = count == Depth;
    empty        = wptr == rptr;
    almost_full  = count >= AfLvl;
    almost_empty = count <= AeLvl;
    en           = rst && (ce == ChipEnable);
    push_ok      = en && push && !full;
    pop_ok       = en && pop && !empty;
    push_err     = en && push && full;
    pop_err      = en && pop && empty;
    sram_ce      = ce;
    sram_we      = push_ok ? WriteEnable : !WriteEnable;
    sram_re      = pop_ok ? ReadEnable : !ReadEnable;
    sram_waddr   = wptr[ADDR_WIDTH-1:0];
    sram_raddr   = rptr[ADDR_WIDTH-1:0];
    sram_wdata   = push_data;
    pop_data     = sram_rdata;
    pop_valid_d  = pop_ok;
    overflow_d   = push_err || (overflow_q && !clr_err);
    underflow_d  = pop_err || (underflow_q && !clr_err);
  end
  // pop_valid tracks the SRAM's one-cycle read latency; error flags are sticky
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  assign pop_valid = pop_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: randomized self-checking bench for fifo_ctrl against a queue-based model
module tb_fifo_ctrl;
  logic clk = 1'b0;
  logic rst, ce, push, pop, clr_err;
  logic [7:0] push_data, pop_data, sram_wdata, sram_rdata;
  logic pop_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  logic sram_ce, sram_we, sram_re;
  logic [3:0] sram_waddr, sram_raddr;
  logic [7:0] mem [16];
  int n_vec = 0, n_err = 0;
  int wcnt, rcnt;
  logic [7:0] q [$];
  logic m_ovf, m_unf, m_pv;
  logic [7:0] m_pd;

  fifo_ctrl dut (
    .clk(clk), .rst(rst), .ce(ce), .push(push), .push_data(push_data),
    .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err),
    .sram_ce(sram_ce), .sram_waddr(sram_waddr), .sram_we(sram_we),
    .sram_wdata(sram_wdata), .sram_raddr(sram_raddr), .sram_re(sram_re),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_ce && sram_we) mem[sram_waddr] <= sram_wdata;
    if (sram_ce && sram_re) sram_rdata <= mem[sram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_pv  = 1'b0;
    wcnt  = 0;
    rcnt  = 0;
  endtask

  task automatic check_state();
    chk("count", count, q.size());
    chk("full", full, q.size() == 16);
    chk("empty", empty, q.size() == 0);
    chk("almost_full", almost_full, q.size() >= 14);
    chk("almost_empty", almost_empty, q.size() <= 2);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    chk("pop_valid", pop_valid, m_pv);
    if (m_pv) chk("pop_data", pop_data, m_pd);
  endtask

  task automatic step(input logic p, input logic o, input logic [7:0] d, input logic c, input logic clr);
    logic ap, ao;
    int n;
    push = p; pop = o; push_data = d; ce = c; clr_err = clr;
    n  = q.size();
    ap = p && c && n < 16;
    ao = o && c && n > 0;
    #1;
    chk("sram_we", sram_we, ap);
    chk("sram_re", sram_re, ao);
    chk("sram_ce", sram_ce, c);
    if (ap) begin
      chk("sram_waddr", sram_waddr, wcnt % 16);
      chk("sram_wdata", sram_wdata, d);
    end
    if (ao) chk("sram_raddr", sram_raddr, rcnt % 16);
    @(posedge clk);
    m_pv = ao;
    if (ao) begin
      m_pd = q.pop_front();
      rcnt++;
    end
    if (ap) begin
      q.push_back(d);
      wcnt++;
    end
    m_ovf = (p && c && n == 16) || (m_ovf && !clr);
    m_unf = (o && c && n == 0) || (m_unf && !clr);
    #1;
    check_state();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; ce = 1'b1; push = 1'b1; pop = 1'b1; push_data = 8'h5A; clr_err = 1'b0;
    model_reset();
    #3;
    chk("rst_we", sram_we, 1'b0);
    chk("rst_re", sram_re, 1'b0);
    check_state();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) step(1, 0, 8'(8'h11 + i), 1, 0);
    chk("fill15_count", count, 15);
    chk("fill15_af", almost_full, 1);
    chk("fill15_full", full, 0);
    step(1, 0, 8'h20, 1, 0);
    chk("fill16_full", full, 1);
    chk("fill16_count", count, 16);
    step(1, 0, 8'hEE, 1, 0);
    chk("ovf_on_full", overflow, 1);
    chk("ovf_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'h00, 1, 0);
      chk("drain_valid", pop_valid, 1);
      chk("drain_data", pop_data, 8'(8'h11 + i));
    end
    step(0, 0, 8'h00, 1, 0);
    chk("drain_empty", empty, 1);
    chk("drain_valid_end", pop_valid, 0);
    step(0, 1, 8'h00, 1, 0);
    chk("unf_on_empty", underflow, 1);
    chk("unf_no_valid", pop_valid, 0);
    step(0, 1, 8'h00, 1, 1);
    chk("unf_priority", underflow, 1);
    step(0, 0, 8'h00, 1, 1);
    chk("clr_ovf", overflow, 0);
    chk("clr_unf", underflow, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'($urandom), 1, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 8'($urandom), 1, 0);
    chk("stream_count", count, 3);
    step(0, 1, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 8'($urandom), 0, 0);
    chk("ce_off_count", count, 2);
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 7) != 0,
           $urandom_range(0, 15) == 0);
    for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom), 1, 0);
    step(0, 1, 8'h00, 1, 0);
    chk("pre_rst_valid", pop_valid, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_empty", empty, 1);
    chk("async_count", count, 0);
    chk("async_valid", pop_valid, 0);
    chk("async_re", sram_re, 0);
    model_reset();
    push = 1'b0; pop = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 8'hAA, 1, 0);
    step(0, 1, 8'h00, 1, 0);
    chk("post_rst_data", pop_data, 8'hAA);
    step(0, 0, 8'h00, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameters SHALL be as follows.
- ADDR_WIDTH, default 4: SRAM address width.
- DATA_WIDTH, default 8: word width.
- DATA_DEPTH, default 16: entries; SHALL equal 2**ADDR_WIDTH.
- AF_LEVEL, default 14: almost_full threshold.
- AE_LEVEL, default 2: almost_empty threshold.

REQ-002 There SHALL be one clock, clk; reset rst SHALL be asynchronous and active-low.

REQ-003 Ports SHALL be as follows.
- clk  in  1  rising-edge clock.
- rst  in  1  async active-low reset.
- ce  in  1  chip enable; when low, no push/pop is accepted.
- push  in  1  write request.
- push_data  in  DATA_WIDTH  write word.
- pop  in  1  read request.
- pop_data  out  DATA_WIDTH  read word.
- pop_valid  out  1  pop_data qualifier.
- full  out  1  count == DATA_DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  occupancy.
- overflow  out  1  sticky: push rejected.
- underflow  out  1  sticky: pop rejected.
- clr_err  in  1  clears overflow/underflow.
- sram_ce  out  1  to SRAM ce (mirrors ce).
- sram_waddr  out  ADDR_WIDTH  SRAM write address.
- sram_we  out  1  SRAM write enable.
- sram_wdata  out  DATA_WIDTH  SRAM write data.
- sram_raddr  out  ADDR_WIDTH  SRAM read address.
- sram_re  out  1  SRAM read enable.
- sram_rdata  in  DATA_WIDTH  SRAM registered read data (1-cycle latency).

Function
REQ-004 A push SHALL be accepted iff push && ce && !full.
REQ-005 A pop SHALL be accepted iff pop && ce && !empty.
REQ-006 Accepted-push outputs SHALL be combinational in the same cycle: sram_we=1, sram_waddr=wptr[ADDR_WIDTH-1:0], sram_wdata=push_data.
REQ-007 Accepted-pop outputs SHALL be combinational in the same cycle: sram_re=1, sram_raddr=rptr[ADDR_WIDTH-1:0].
REQ-008 wptr and rptr SHALL be ADDR_WIDTH+1 bits, increment by 1 on their accepted operation, and wrap modulo 2**(ADDR_WIDTH+1).
REQ-009 Flags SHALL be derived from the pointers:
- full = (pointers differ only in MSB).
- empty = (pointers equal).
- count = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
REQ-010 pop_valid SHALL assert exactly one cycle after an accepted pop, for one cycle per pop; pop_data SHALL equal sram_rdata while pop_valid=1.
REQ-011 Back-to-back pops SHALL yield pop_valid high on consecutive cycles, in order, with no bubbles.
REQ-012 Simultaneous push and pop:
- Neither full nor empty: both SHALL be accepted; count unchanged.
- Empty: only the push SHALL be accepted; underflow SHALL set.
- Full: only the pop SHALL be accepted; overflow SHALL set.
REQ-013 A push while full or a pop while empty SHALL set the corresponding sticky flag on the next edge; pointers SHALL be unchanged.
REQ-014 clr_err=1 SHALL clear both sticky flags on the next edge; a new violation in the same cycle SHALL take priority (flag stays 1).
REQ-015 With ce=0, sram_we=sram_re=0 and pointers SHALL hold; push/pop SHALL NOT set the sticky flags.
REQ-016 The block SHALL be fully synchronous to clk except for reset.

Reset
REQ-017 While rst=0, the following SHALL hold:
- wptr=rptr=0, count=0, empty=1, full=0.
- almost_empty=1, almost_full=0.
- pop_valid=0, overflow=0, underflow=0.
- sram_we=0, sram_re=0.
REQ-018 Reset asserted mid-operation SHALL discard stored contents logically (empty=1) and SHALL drop any pending pop_valid.
REQ-019 Push/pop SHALL be accepted from the first rising edge after rst deasserts.

Structure
REQ-020 The shared defines file SHALL hold the enable-polarity constants (ChipEnable, WriteEnable, ReadEnable); the block SHALL use them for ce, sram_we and sram_re.
REQ-021 One sub-module, fifo_ptr, SHALL be used: an (ADDR_WIDTH+1)-bit wrap counter with inc, instantiated twice (write and read pointers).
REQ-022 The SRAM SHALL be instantiated outside this block; sram_* ports SHALL connect directly, with both SRAM clocks tied to clk.

Verification
REQ-023 Reset, then push 0x11..0x1F (15 words) -> count=15, almost_full=1, full=0; one more push 0x20 -> full=1, count=16.
REQ-024 From full, pop 16 times back-to-back -> pop_valid for 16 consecutive cycles, starting one cycle after the first pop, data 0x11..0x20 in order; then empty=1.
REQ-025 Push and pop every cycle for 40 cycles at count=3 -> count stays 3, both pointers wrap, output order preserved.
REQ-026 Pop on empty -> underflow=1 and pop_valid stays 0; push on full -> overflow=1 and count stays 16; clr_err -> both flags 0.
REQ-027 Push 5 words, assert rst=0 asynchronously between edges -> empty=1, count=0, pop_valid=0 immediately; after release, push 0xAA then pop -> 0xAA returned.
REQ-028 ce=0 with push=pop=1 for 3 cycles -> no SRAM enables, count unchanged, sticky flags unchanged.
